uart_rx: RTL and testbench

//  8N1 serial receiver; counterpart of the uart transmitter on the CPU's UART_ADDR port.

---
 rtl/uart_rx_if.sv | 30 +++
 rtl/uart_rx.sv | 163 ++++++++++++++++
 tb/tb_uart_rx.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Core-side bundle of the UART receiver: pop/clear strobes in, FIFO head byte and status out.
interface uart_rx_if;
    logic       uart_rd_i;
    logic       uart_clr_i;
    logic [7:0] uart_dat_o;
    logic       uart_empty_o;
    logic       uart_full_o;
    logic       uart_ovr_o;
    logic       uart_ferr_o;

    modport slave (
        input  uart_rd_i,
        input  uart_clr_i,
        output uart_dat_o,
        output uart_empty_o,
        output uart_full_o,
        output uart_ovr_o,
        output uart_ferr_o
    );

    modport master (
        output uart_rd_i,
        output uart_clr_i,
        input  uart_dat_o,
        input  uart_empty_o,
        input  uart_full_o,
        input  uart_ovr_o,
        input  uart_ferr_o
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver: mid-bit sampling FSM feeding a first-word fall-through byte FIFO,
// with sticky overrun and framing-error flags.
module uart_rx #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic     sys_clk_i,
    input  logic     sys_rstn_i,
    input  logic     uart_rx_i,
    uart_rx_if.slave bus
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
    localparam int unsigned AW           = $clog2(FIFO_DEPTH);
    localparam int unsigned PW           = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    logic          sync1_q, rxs_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          push_c, ferr_set_c;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          empty_q, empty_d, full_q, full_d;
    logic          ovr_q, ovr_d, ferr_q, ferr_d;
    logic          pop_c, wr_en_c, ovr_set_c;

    // Two-flop synchronizer; the line idles high, so reset to 1
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= uart_rx_i;
            rxs_q   <= sync1_q;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    // Frame FSM; cnt restarts from zero on every state change
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        push_c     = 1'b0;
        ferr_set_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == CW'(HALF_BIT - 1)) begin
                    cnt_d = '0;
                    if (!rxs_q) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rxs_q;
                    if (idx_q == 3'd7) state_d = S_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        push_c  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_set_c = 1'b1;
                        state_d    = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rxs_q) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO control: a pop frees the slot a simultaneous push needs, so full+pop is no overrun
    always_comb begin
        pop_c     = bus.uart_rd_i && !empty_q;
        wr_en_c   = push_c && (!full_q || pop_c);
        ovr_set_c = push_c && full_q && !pop_c;
        mem_d     = mem_q;
        if (wr_en_c) mem_d[wr_ptr_q[AW-1:0]] = shreg_q;
        wr_ptr_d  = wr_ptr_q + PW'(wr_en_c);
        rd_ptr_d  = rd_ptr_q + PW'(pop_c);
        empty_d   = (wr_ptr_d == rd_ptr_d);
        full_d    = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
        ovr_d     = ovr_set_c  ? 1'b1 : (bus.uart_clr_i ? 1'b0 : ovr_q);
        ferr_d    = ferr_set_c ? 1'b1 : (bus.uart_clr_i ? 1'b0 : ferr_q);
    end

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
        end
    end

    assign bus.uart_dat_o   = mem_q[rd_ptr_q[AW-1:0]];
    assign bus.uart_empty_o = empty_q;
    assign bus.uart_full_o  = full_q;
    assign bus.uart_ovr_o   = ovr_q;
    assign bus.uart_ferr_o  = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit with a 4-entry FIFO.
module tb_uart_rx;
    localparam int unsigned CLK_FREQ = 1_600_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned CPB      = 16;

    logic clk = 1'b0;
    logic rstn;
    logic rx;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    uart_rx_if bus();

    always #5 clk = ~clk;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(4)) dut (
        .sys_clk_i (clk),
        .sys_rstn_i(rstn),
        .uart_rx_i (rx),
        .bus       (bus)
    );

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Start bit, LSB-first data, stop bit; optionally pop in the cycle the byte is pushed
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit pop_at_push);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        rx = stop;
        if (pop_at_push) begin
            repeat (10) @(negedge clk);
            bus.uart_rd_i = 1'b1;
            @(negedge clk);
            bus.uart_rd_i = 1'b0;
            repeat (CPB - 11) @(negedge clk);
        end else begin
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic pop_byte();
        bus.uart_rd_i = 1'b1;
        @(negedge clk);
        bus.uart_rd_i = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.uart_clr_i = 1'b1;
        @(negedge clk);
        bus.uart_clr_i = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        rx   = 1'b1;
        bus.uart_rd_i  = 1'b0;
        bus.uart_clr_i = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++; if (bus.uart_dat_o !== 8'h00) $display("FAIL reset_dat: got %h want 00", bus.uart_dat_o); else pass_cnt++;
        total_cnt++; if (bus.uart_empty_o !== 1'b1) $display("FAIL reset_empty: got %b want 1", bus.uart_empty_o); else pass_cnt++;
        total_cnt++; if (bus.uart_full_o !== 1'b0) $display("FAIL reset_full: got %b want 0", bus.uart_full_o); else pass_cnt++;
        total_cnt++; if ({bus.uart_ovr_o, bus.uart_ferr_o} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {bus.uart_ovr_o, bus.uart_ferr_o}); else pass_cnt++;
        rstn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_byte();
        int lat;
        lat = 0;
        fork
            send_frame(8'h55, 1'b1, 1'b0);
            begin
                while (bus.uart_empty_o === 1'b1 && lat < 200) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        total_cnt++; if (lat < 152 || lat > 158) $display("FAIL single_latency: got %0d clk want 152..158", lat); else pass_cnt++;
        total_cnt++; if (bus.uart_dat_o !== 8'h55) $display("FAIL single_dat: got %h want 55", bus.uart_dat_o); else pass_cnt++;
        total_cnt++; if ({bus.uart_ovr_o, bus.uart_ferr_o, bus.uart_full_o} !== 3'b000) $display("FAIL single_flags: got %b want 000", {bus.uart_ovr_o, bus.uart_ferr_o, bus.uart_full_o}); else pass_cnt++;
        pop_byte();
        total_cnt++; if (bus.uart_empty_o !== 1'b1) $display("FAIL single_pop_empty: got %b want 1", bus.uart_empty_o); else pass_cnt++;
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        total_cnt++; if (bus.uart_empty_o !== 1'b1) $display("FAIL glitch_empty: got %b want 1", bus.uart_empty_o); else pass_cnt++;
        total_cnt++; if ({bus.uart_ovr_o, bus.uart_ferr_o} !== 2'b00) $display("FAIL glitch_flags: got %b want 00", {bus.uart_ovr_o, bus.uart_ferr_o}); else pass_cnt++;
    endtask

    task automatic test_framing();
        send_frame(8'hA5, 1'b0, 1'b0);
        repeat (CPB) @(negedge clk);
        total_cnt++; if (bus.uart_ferr_o !== 1'b1) $display("FAIL ferr_set: got %b want 1", bus.uart_ferr_o); else pass_cnt++;
        total_cnt++; if (bus.uart_empty_o !== 1'b1) $display("FAIL ferr_empty: got %b want 1", bus.uart_empty_o); else pass_cnt++;
        pulse_clr();
        total_cnt++; if (bus.uart_ferr_o !== 1'b0) $display("FAIL ferr_clr: got %b want 0", bus.uart_ferr_o); else pass_cnt++;
        rx = 1'b0;
        repeat (20 * CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        total_cnt++; if ({bus.uart_ferr_o, bus.uart_ovr_o, bus.uart_empty_o} !== 3'b101) $display("FAIL break_state: ferr,ovr,empty got %b want 101", {bus.uart_ferr_o, bus.uart_ovr_o, bus.uart_empty_o}); else pass_cnt++;
        pulse_clr();
        send_frame(8'h3C, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        total_cnt++; if (bus.uart_empty_o !== 1'b0) $display("FAIL after_break_empty: got %b want 0", bus.uart_empty_o); else pass_cnt++;
        total_cnt++; if (bus.uart_dat_o !== 8'h3C) $display("FAIL after_break_dat: got %h want 3c", bus.uart_dat_o); else pass_cnt++;
        total_cnt++; if (bus.uart_ferr_o !== 1'b0) $display("FAIL after_break_ferr: got %b want 0", bus.uart_ferr_o); else pass_cnt++;
        pop_byte();
    endtask

    task automatic test_overrun();
        logic [7:0] exp;
        for (int i = 1; i <= 3; i++) send_frame(8'(i), 1'b1, 1'b0);
        total_cnt++; if (bus.uart_full_o !== 1'b0) $display("FAIL ovr_full_at3: got %b want 0", bus.uart_full_o); else pass_cnt++;
        send_frame(8'h04, 1'b1, 1'b0);
        total_cnt++; if (bus.uart_full_o !== 1'b1) $display("FAIL ovr_full_at4: got %b want 1", bus.uart_full_o); else pass_cnt++;
        total_cnt++; if (bus.uart_ovr_o !== 1'b0) $display("FAIL ovr_early: got %b want 0", bus.uart_ovr_o); else pass_cnt++;
        send_frame(8'h05, 1'b1, 1'b0);
        total_cnt++; if ({bus.uart_ovr_o, bus.uart_full_o} !== 2'b11) $display("FAIL ovr_set: ovr,full got %b want 11", {bus.uart_ovr_o, bus.uart_full_o}); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            exp = 8'(i + 1);
            total_cnt++; if (bus.uart_dat_o !== exp) $display("FAIL ovr_pop%0d: got %h want %h", i, bus.uart_dat_o, exp); else pass_cnt++;
            pop_byte();
        end
        total_cnt++; if (bus.uart_empty_o !== 1'b1) $display("FAIL ovr_drained: got %b want 1", bus.uart_empty_o); else pass_cnt++;
        pulse_clr();
        total_cnt++; if (bus.uart_ovr_o !== 1'b0) $display("FAIL ovr_clr: got %b want 0", bus.uart_ovr_o); else pass_cnt++;
    endtask

    task automatic test_push_pop_full();
        logic [7:0] exp;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
        send_frame(8'h05, 1'b1, 1'b1);
        total_cnt++; if ({bus.uart_ovr_o, bus.uart_full_o} !== 2'b01) $display("FAIL pp_flags: ovr,full got %b want 01", {bus.uart_ovr_o, bus.uart_full_o}); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            exp = 8'(i + 2);
            total_cnt++; if (bus.uart_dat_o !== exp) $display("FAIL pp_pop%0d: got %h want %h", i, bus.uart_dat_o, exp); else pass_cnt++;
            pop_byte();
        end
        total_cnt++; if (bus.uart_empty_o !== 1'b1) $display("FAIL pp_drained: got %b want 1", bus.uart_empty_o); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] f0;
        f0 = 8'hF0;
        send_frame(8'h7E, 1'b1, 1'b0);
        total_cnt++; if (bus.uart_dat_o !== 8'h7E) $display("FAIL rm_pre_dat: got %h want 7e", bus.uart_dat_o); else pass_cnt++;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(f0[i]);
        rstn = 1'b0;
        rx   = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++; if (bus.uart_dat_o !== 8'h00) $display("FAIL rm_dat: got %h want 00", bus.uart_dat_o); else pass_cnt++;
        total_cnt++; if ({bus.uart_empty_o, bus.uart_full_o, bus.uart_ovr_o, bus.uart_ferr_o} !== 4'b1000) $display("FAIL rm_status: empty,full,ovr,ferr got %b want 1000", {bus.uart_empty_o, bus.uart_full_o, bus.uart_ovr_o, bus.uart_ferr_o}); else pass_cnt++;
        rstn = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        total_cnt++; if (bus.uart_empty_o !== 1'b1) $display("FAIL rm_no_partial: got %b want 1", bus.uart_empty_o); else pass_cnt++;
        send_frame(8'h81, 1'b1, 1'b0);
        total_cnt++; if (bus.uart_dat_o !== 8'h81) $display("FAIL rm_dat81: got %h want 81", bus.uart_dat_o); else pass_cnt++;
        pop_byte();
        total_cnt++; if (bus.uart_empty_o !== 1'b1) $display("FAIL rm_only81: got %b want 1", bus.uart_empty_o); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_framing();
        test_overrun();
        test_push_pop_full();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
